// File: rtl/dram_ring_pkg.sv
// Shared definitions for the DRAM ring readout path.
// Drainer FSM encodings, DRAM tag width and header field offsets.
package dram_ring_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    STREAM = 3'd2,
    GAP    = 3'd3
  } state_t;

  localparam int TAG_W       = 25;
  localparam int HDR_TAG_LSB = 0;
  localparam int HDR_CNT_LSB = 25;

endpackage

// File: rtl/bram_sdp_reg.sv
// Simple dual-port RAM, one write port and one registered read port.
// Read data appears the cycle after re and holds until the next read.
module bram_sdp_reg #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_burst_drainer.sv
// Stages read-controller words in a circular BRAM, drains fixed bursts.
// Define BURST_HDR_EN to prefix each burst with a tag/count header word.
module bram_burst_drainer
  import dram_ring_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 9,
  parameter int BURST_LEN   = 128,
  parameter int FULL_THRESH = 448
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_we,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              bram_full,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic [2:0]        state
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] BLEN_L  = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0] FULL_L  = (ADDR_W+1)'(FULL_THRESH);

  state_t            st, nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   burst_cnt, issued, cnt_load;
  logic              wr_ok, rd_issue, hdr_push, load;
  logic              pop, push, room;
  logic              rd_pend, rd_last_pend;
  logic [1:0]        sk_cnt;
  logic [2:0]        occ;
  logic [DATA_W-1:0] rdata, push_data, sk_d0, sk_d1;
  logic              sk_l0, sk_l1;

  assign wr_ok = in_we && (fill_level != DEPTH_L);
  assign pop   = (sk_cnt != 2'd0) && out_ready;
  assign occ   = {1'b0, sk_cnt} + {2'b00, rd_pend};
  assign room  = occ < (3'd2 + {2'b00, pop});
  assign push  = rd_pend || hdr_push;

  assign out_valid = (sk_cnt != 2'd0);
  assign out_data  = sk_d0;
  assign out_last  = sk_l0 && out_valid;
  assign state     = st;

  bram_sdp_reg #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_data (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr),
    .wdata(in_data),
    .re   (rd_issue),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

`ifdef BURST_HDR_EN
  logic [TAG_W-1:0]  tag_rdata;
  logic [DATA_W-1:0] hdr_word;

  bram_sdp_reg #(
    .DATA_W(TAG_W),
    .ADDR_W(ADDR_W)
  ) u_tag (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr),
    .wdata(in_tag),
    .re   (load),
    .raddr(rd_ptr),
    .rdata(tag_rdata)
  );

  // header: first-word tag in the low bits, burst count above it
  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_TAG_LSB +: TAG_W]  = tag_rdata;
    hdr_word[HDR_CNT_LSB +: ADDR_W+1] = burst_cnt;
  end

  assign push_data = hdr_push ? hdr_word : rdata;
`else
  logic unused_tag;
  assign unused_tag = ^in_tag;
  assign push_data  = rdata;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= nxt;
  end

  // next state, burst arming and read issue
  always_comb begin
    nxt      = st;
    rd_issue = 1'b0;
    hdr_push = 1'b0;
    load     = 1'b0;
    cnt_load = '0;
    case (st)
      IDLE: begin
        if (fill_level >= BLEN_L) begin
          load     = 1'b1;
          cnt_load = BLEN_L;
          nxt      = ARM;
        end else if (flush && fill_level != '0) begin
          load     = 1'b1;
          cnt_load = fill_level;
          nxt      = ARM;
        end
      end
      ARM: begin
`ifdef BURST_HDR_EN
        hdr_push = room;
        if (room) nxt = STREAM;
`else
        nxt = STREAM;
`endif
      end
      STREAM: begin
        rd_issue = room && (issued < burst_cnt);
        if (pop && sk_l0) nxt = GAP;
      end
      GAP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // pointers, fill accounting, back-pressure and overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      bram_full    <= 1'b0;
      overflow     <= 1'b0;
      burst_cnt    <= '0;
      issued       <= '0;
      rd_pend      <= 1'b0;
      rd_last_pend <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (in_we && !wr_ok) overflow <= 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_issue})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
      bram_full <= (fill_level >= FULL_L);
      if (load) begin
        burst_cnt <= cnt_load;
        issued    <= '0;
      end else if (rd_issue) begin
        issued <= issued + 1'b1;
      end
      rd_pend      <= rd_issue;
      rd_last_pend <= rd_issue && (issued + 1'b1 == burst_cnt);
    end
  end

  // two-entry skid buffer; head entry drives the stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk_cnt <= 2'd0;
      sk_d0  <= '0;
      sk_d1  <= '0;
      sk_l0  <= 1'b0;
      sk_l1  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) begin
            sk_d0 <= push_data;
            sk_l0 <= rd_last_pend;
          end else begin
            sk_d1 <= push_data;
            sk_l1 <= rd_last_pend;
          end
          sk_cnt <= sk_cnt + 1'b1;
        end
        2'b01: begin
          sk_d0  <= sk_d1;
          sk_l0  <= sk_l1;
          sk_cnt <= sk_cnt - 1'b1;
        end
        2'b11: begin
          if (sk_cnt == 2'd1) begin
            sk_d0 <= push_data;
            sk_l0 <= rd_last_pend;
          end else begin
            sk_d0 <= sk_d1;
            sk_l0 <= sk_l1;
            sk_d1 <= push_data;
            sk_l1 <= rd_last_pend;
          end
        end
        default: sk_cnt <= sk_cnt;
      endcase
    end
  end

endmodule
